// File: rtl/smp_to_word.sv
// smp_to_word: fetches samples from a BRAM read port and splits each into OUT_WIDTH-bit words
// under a valid/ready handshake, stopping after a programmed sample count.
// Optional macro SMP_TO_WORD_CHECKSUM_EN appends an XOR checksum word after the last data word.
module smp_to_word #(
  parameter int unsigned SAMPLE_WIDTH = 24,
  parameter int unsigned OUT_WIDTH    = 8,
  parameter int unsigned MSB_FIRST    = 0,
  parameter int unsigned RD_LATENCY   = 1,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input  logic                    i_clk_ILA,
  input  logic                    i_reset,
  input  logic                    i_read_active,
  input  logic [CNT_WIDTH-1:0]    i_num_samples,
  input  logic [SAMPLE_WIDTH-1:0] i_ram_sample,
  output logic                    o_rd,
  output logic [OUT_WIDTH-1:0]    o_send_word,
  output logic                    o_send_valid,
  input  logic                    i_send_ready,
  output logic                    o_last,
  output logic                    o_done
);

  localparam int unsigned N    = (SAMPLE_WIDTH + OUT_WIDTH - 1) / OUT_WIDTH;
  localparam int unsigned PadW = N * OUT_WIDTH;
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned LatW = $clog2(RD_LATENCY + 1);

`ifdef SMP_TO_WORD_CHECKSUM_EN
  typedef enum logic [2:0] {StIdle, StWait, StSend, StDone, StCheck} state_e;
`else
  typedef enum logic [1:0] {StIdle, StWait, StSend, StDone} state_e;
`endif

  state_e                state_q, state_d;
  logic                  act_q;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [LatW-1:0]       lat_q, lat_d;
  logic [PadW-1:0]       sr_q, sr_d;
  logic                  rd_q, rd_d;
  logic [PadW-1:0]       padded;
  logic [OUT_WIDTH-1:0]  head_word;
  logic [PadW-1:0]       sr_shifted;
`ifdef SMP_TO_WORD_CHECKSUM_EN
  logic [OUT_WIDTH-1:0]  xor_q, xor_d;
`endif

  // Zero-pad the sample and pick the word at the emitting end of the shift register
  always_comb begin
    padded = '0;
    padded[SAMPLE_WIDTH-1:0] = i_ram_sample;
    if (MSB_FIRST != 0) begin
      head_word  = sr_q[PadW-1 -: OUT_WIDTH];
      sr_shifted = sr_q << OUT_WIDTH;
    end else begin
      head_word  = sr_q[OUT_WIDTH-1:0];
      sr_shifted = sr_q >> OUT_WIDTH;
    end
  end

  // Next-state and output decode
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    lat_d        = lat_q;
    sr_d         = sr_q;
    rd_d         = 1'b0;
    o_send_valid = 1'b0;
    o_send_word  = '0;
    o_last       = 1'b0;
    o_done       = 1'b0;
`ifdef SMP_TO_WORD_CHECKSUM_EN
    xor_d        = xor_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (i_read_active && !act_q) begin
          cnt_d = i_num_samples;
          lat_d = '0;
          idx_d = '0;
`ifdef SMP_TO_WORD_CHECKSUM_EN
          xor_d = '0;
          state_d = (i_num_samples == '0) ? StCheck : StWait;
`else
          state_d = (i_num_samples == '0) ? StDone : StWait;
`endif
        end
      end
      StWait: begin
        // The o_rd cycle itself is not counted: the next sample appears RD_LATENCY cycles after it
        if (!rd_q) begin
          if (lat_q == LatW'(RD_LATENCY - 1)) begin
            sr_d    = padded;
            idx_d   = '0;
            state_d = StSend;
          end else begin
            lat_d = lat_q + 1'b1;
          end
        end
      end
      StSend: begin
        o_send_valid = 1'b1;
        o_send_word  = head_word;
`ifndef SMP_TO_WORD_CHECKSUM_EN
        o_last = (idx_q == IdxW'(N - 1)) && (cnt_q == CNT_WIDTH'(1));
`endif
        if (i_send_ready) begin
          sr_d = sr_shifted;
`ifdef SMP_TO_WORD_CHECKSUM_EN
          xor_d = xor_q ^ head_word;
`endif
          if (idx_q == IdxW'(N - 1)) begin
            rd_d  = 1'b1;
            cnt_d = cnt_q - 1'b1;
            idx_d = '0;
            lat_d = '0;
            if (cnt_q == CNT_WIDTH'(1)) begin
`ifdef SMP_TO_WORD_CHECKSUM_EN
              state_d = StCheck;
`else
              state_d = StDone;
`endif
            end else begin
              state_d = StWait;
            end
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
`ifdef SMP_TO_WORD_CHECKSUM_EN
      StCheck: begin
        o_send_valid = 1'b1;
        o_send_word  = xor_q;
        o_last       = 1'b1;
        if (i_send_ready) state_d = StDone;
      end
`endif
      StDone: begin
        o_done = 1'b1;
      end
      default: state_d = StIdle;
    endcase
    // Dropping i_read_active aborts from any state, discarding an unaccepted word
    if (!i_read_active) begin
      state_d = StIdle;
      cnt_d   = '0;
      idx_d   = '0;
      lat_d   = '0;
      sr_d    = '0;
      rd_d    = 1'b0;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge i_clk_ILA) begin
    if (i_reset) begin
      state_q <= StIdle;
      act_q   <= 1'b0;
      cnt_q   <= '0;
      idx_q   <= '0;
      lat_q   <= '0;
      sr_q    <= '0;
      rd_q    <= 1'b0;
`ifdef SMP_TO_WORD_CHECKSUM_EN
      xor_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      act_q   <= i_read_active;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      lat_q   <= lat_d;
      sr_q    <= sr_d;
      rd_q    <= rd_d;
`ifdef SMP_TO_WORD_CHECKSUM_EN
      xor_q   <= xor_d;
`endif
    end
  end

  assign o_rd = rd_q;

endmodule
